// File: rtl/fft_pkg.sv
// fft_pkg -- shared constants for the radix-4 butterfly datapath.
//   DW_DEF / TW_DEF : default sample and twiddle widths
//   CMUL_LAT        : complex multiplier pipeline depth
//   ADD_LAT         : butterfly adder pipeline depth
//   BFLY_LAT        : in_valid to out_valid latency
//   scale_e         : encoding of the 2-bit output scale input
package fft_pkg;

   localparam int DW_DEF   = 16;
   localparam int TW_DEF   = 16;
   localparam int CMUL_LAT = 3;
   localparam int ADD_LAT  = 2;
   localparam int BFLY_LAT = CMUL_LAT + ADD_LAT;

   // Right-shift applied to each butterfly sum; code 3 aliases shift-by-2.
   typedef enum logic [1:0] {
      SCALE_NONE        = 2'd0,
      SCALE_HALF        = 2'd1,
      SCALE_QUARTER     = 2'd2,
      SCALE_QUARTER_ALT = 2'd3
   } scale_e;

   // Map the raw scale code to the actual shift amount (0..2).
   function automatic logic [1:0] scale_shift(input logic [1:0] sc);
      return (scale_e'(sc) == SCALE_QUARTER_ALT) ? 2'd2 : sc;
   endfunction

endpackage

// File: rtl/cmul_pipe.sv
// cmul_pipe -- 3-stage pipelined complex multiply y = x * w, w = w_re + j*w_im.
//   Stage 1 registers operands, stage 2 registers the four partial products,
//   stage 3 registers the rounded result.
//   clk, rst      : clock, asynchronous active-high reset
//   x_re, x_im    : signed DW-bit operand
//   w_re, w_im    : signed twiddle in Q1.(TW-1)
//   y_re, y_im    : signed DW-bit product, rounded by adding 2^(TW-2) and
//                   arithmetically shifting right by TW-1, then wrapped to DW bits
module cmul_pipe
   import fft_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int TW = TW_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic signed [DW-1:0] x_re,
   input  logic signed [DW-1:0] x_im,
   input  logic signed [TW-1:0] w_re,
   input  logic signed [TW-1:0] w_im,
   output logic signed [DW-1:0] y_re,
   output logic signed [DW-1:0] y_im
);

   localparam int PW = DW + TW;      // width of a single partial product
   localparam int SW = PW + 1;       // width of a sum of two products
   localparam logic signed [SW-1:0] RND = SW'(64'sd1 <<< (TW - 2));

   logic signed [DW-1:0] x_re_q, x_re_d, x_im_q, x_im_d;
   logic signed [TW-1:0] w_re_q, w_re_d, w_im_q, w_im_d;
   logic signed [PW-1:0] rr_q, rr_d, ii_q, ii_d, ri_q, ri_d, ir_q, ir_d;
   logic signed [DW-1:0] y_re_q, y_re_d, y_im_q, y_im_d;

   always_comb begin
      x_re_d = x_re;
      x_im_d = x_im;
      w_re_d = w_re;
      w_im_d = w_im;
      rr_d   = PW'(x_re_q) * PW'(w_re_q);
      ii_d   = PW'(x_im_q) * PW'(w_im_q);
      ri_d   = PW'(x_re_q) * PW'(w_im_q);
      ir_d   = PW'(x_im_q) * PW'(w_re_q);
      y_re_d = DW'((SW'(rr_q) - SW'(ii_q) + RND) >>> (TW - 1));
      y_im_d = DW'((SW'(ri_q) + SW'(ir_q) + RND) >>> (TW - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_re_q <= '0;
         x_im_q <= '0;
         w_re_q <= '0;
         w_im_q <= '0;
         rr_q   <= '0;
         ii_q   <= '0;
         ri_q   <= '0;
         ir_q   <= '0;
         y_re_q <= '0;
         y_im_q <= '0;
      end else begin
         x_re_q <= x_re_d;
         x_im_q <= x_im_d;
         w_re_q <= w_re_d;
         w_im_q <= w_im_d;
         rr_q   <= rr_d;
         ii_q   <= ii_d;
         ri_q   <= ri_d;
         ir_q   <= ir_d;
         y_re_q <= y_re_d;
         y_im_q <= y_im_d;
      end
   end

   assign y_re = y_re_q;
   assign y_im = y_im_q;

endmodule

// File: rtl/butterfly_radix4_pipe.sv
// butterfly_radix4_pipe -- pipelined radix-4 DIT butterfly, 5-cycle latency,
// one butterfly per cycle, no backpressure.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid            : qualifies x1..x4, twiddles, inv and scale
//   x1..x4 (_re/_im)    : operands; x2..x4 are multiplied by W0..W2
//   cos0/sin0..cos2/sin2: twiddles W = cos + j*sin in Q1.(TW-1)
//   inv                 : 0 forward (-j rotations), 1 inverse (+j rotations)
//   scale               : output right-shift 0/1/2 with rounding (3 means 2)
//   ovf_clr             : synchronous clear of ovf_sticky (a new overflow wins)
//   out_valid, p1..p4   : results; p holds its value when out_valid is low
//   ovf_sticky          : set when any valid scaled result did not fit DW bits
// Build option: define BFLY_R4_SATURATE_EN to clamp overflowed results;
// otherwise they wrap by two's-complement truncation.
module butterfly_radix4_pipe
   import fft_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int TW = TW_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] x1_re, x1_im, x2_re, x2_im,
   input  logic signed [DW-1:0] x3_re, x3_im, x4_re, x4_im,
   input  logic signed [TW-1:0] cos0, sin0, cos1, sin1, cos2, sin2,
   input  logic                 inv,
   input  logic [1:0]           scale,
   input  logic                 ovf_clr,
   output logic                 out_valid,
   output logic signed [DW-1:0] p1_re, p1_im, p2_re, p2_im,
   output logic signed [DW-1:0] p3_re, p3_im, p4_re, p4_im,
   output logic                 ovf_sticky
);

   localparam int SW2 = DW + 2;                 // butterfly sums never overflow here
   localparam int SW3 = DW + 3;                 // room for the rounding add
   localparam int SB  = CMUL_LAT + ADD_LAT - 1; // sideband stages before the output
   localparam logic signed [SW3-1:0] MAXV = {4'b0000, {(DW-1){1'b1}}};
   localparam logic signed [SW3-1:0] MINV = {4'b1111, {(DW-1){1'b0}}};

   function automatic logic signed [SW3-1:0] scale_sum(input logic signed [SW2-1:0] v,
                                                       input logic [1:0] sh);
      logic signed [SW3-1:0] e;
      e = SW3'(v);
      case (sh)
         2'd1:    return (e + SW3'(1)) >>> 1;
         2'd2:    return (e + SW3'(2)) >>> 2;
         default: return e;
      endcase
   endfunction

   // Twiddled operands b, c, d arrive CMUL_LAT cycles after the inputs.
   logic signed [DW-1:0] b_re, b_im, c_re, c_im, d_re, d_im;

   cmul_pipe #(.DW(DW), .TW(TW)) u_cmul_b (
      .clk(clk), .rst(rst), .x_re(x2_re), .x_im(x2_im),
      .w_re(cos0), .w_im(sin0), .y_re(b_re), .y_im(b_im));
   cmul_pipe #(.DW(DW), .TW(TW)) u_cmul_c (
      .clk(clk), .rst(rst), .x_re(x3_re), .x_im(x3_im),
      .w_re(cos1), .w_im(sin1), .y_re(c_re), .y_im(c_im));
   cmul_pipe #(.DW(DW), .TW(TW)) u_cmul_d (
      .clk(clk), .rst(rst), .x_re(x4_re), .x_im(x4_im),
      .w_re(cos2), .w_im(sin2), .y_re(d_re), .y_im(d_im));

   // x1 delay line matching the multiplier, and valid/inv/shift sideband
   // running alongside the data up to the output stage.
   logic signed [DW-1:0] a_re_q [CMUL_LAT], a_re_d [CMUL_LAT];
   logic signed [DW-1:0] a_im_q [CMUL_LAT], a_im_d [CMUL_LAT];
   logic                 v_q [SB], v_d [SB];
   logic                 inv_q [SB], inv_d [SB];
   logic [1:0]           sh_q [SB], sh_d [SB];

   // Partial sums: a+c, a-c, b+d, b-d.
   logic signed [SW2-1:0] acp_re_q, acp_re_d, acp_im_q, acp_im_d;
   logic signed [SW2-1:0] acm_re_q, acm_re_d, acm_im_q, acm_im_d;
   logic signed [SW2-1:0] bdp_re_q, bdp_re_d, bdp_im_q, bdp_im_d;
   logic signed [SW2-1:0] bdm_re_q, bdm_re_d, bdm_im_q, bdm_im_d;

   // Output stage; index order p1_re, p1_im, p2_re, ..., p4_im.
   logic signed [SW2-1:0] sum_v [8];
   logic signed [SW3-1:0] scaled_v [8];
   logic signed [DW-1:0]  res_v [8];
   logic signed [DW-1:0]  p_q [8], p_d [8];
   logic                  ovf_any;
   logic                  out_valid_q, out_valid_d;
   logic                  ovf_sticky_q, ovf_sticky_d;

   always_comb begin
      a_re_d[0] = x1_re;
      a_im_d[0] = x1_im;
      for (int i = 1; i < CMUL_LAT; i++) begin
         a_re_d[i] = a_re_q[i-1];
         a_im_d[i] = a_im_q[i-1];
      end
      v_d[0]   = in_valid;
      inv_d[0] = inv;
      sh_d[0]  = scale_shift(scale);
      for (int i = 1; i < SB; i++) begin
         v_d[i]   = v_q[i-1];
         inv_d[i] = inv_q[i-1];
         sh_d[i]  = sh_q[i-1];
      end

      acp_re_d = SW2'(a_re_q[CMUL_LAT-1]) + SW2'(c_re);
      acp_im_d = SW2'(a_im_q[CMUL_LAT-1]) + SW2'(c_im);
      acm_re_d = SW2'(a_re_q[CMUL_LAT-1]) - SW2'(c_re);
      acm_im_d = SW2'(a_im_q[CMUL_LAT-1]) - SW2'(c_im);
      bdp_re_d = SW2'(b_re) + SW2'(d_re);
      bdp_im_d = SW2'(b_im) + SW2'(d_im);
      bdm_re_d = SW2'(b_re) - SW2'(d_re);
      bdm_im_d = SW2'(b_im) - SW2'(d_im);

      // Forward: p2 = (a-c) - j(b-d), p4 = (a-c) + j(b-d); inverse swaps them.
      sum_v[0] = acp_re_q + bdp_re_q;
      sum_v[1] = acp_im_q + bdp_im_q;
      sum_v[4] = acp_re_q - bdp_re_q;
      sum_v[5] = acp_im_q - bdp_im_q;
      if (!inv_q[SB-1]) begin
         sum_v[2] = acm_re_q + bdm_im_q;
         sum_v[3] = acm_im_q - bdm_re_q;
         sum_v[6] = acm_re_q - bdm_im_q;
         sum_v[7] = acm_im_q + bdm_re_q;
      end else begin
         sum_v[2] = acm_re_q - bdm_im_q;
         sum_v[3] = acm_im_q + bdm_re_q;
         sum_v[6] = acm_re_q + bdm_im_q;
         sum_v[7] = acm_im_q - bdm_re_q;
      end

      ovf_any = 1'b0;
      for (int i = 0; i < 8; i++) begin
         scaled_v[i] = scale_sum(sum_v[i], sh_q[SB-1]);
`ifdef BFLY_R4_SATURATE_EN
         if (scaled_v[i] > MAXV)      res_v[i] = DW'(MAXV);
         else if (scaled_v[i] < MINV) res_v[i] = DW'(MINV);
         else                         res_v[i] = DW'(scaled_v[i]);
`else
         res_v[i] = DW'(scaled_v[i]);
`endif
         if ((scaled_v[i] > MAXV) || (scaled_v[i] < MINV)) ovf_any = 1'b1;
         p_d[i] = v_q[SB-1] ? res_v[i] : p_q[i];
      end

      out_valid_d  = v_q[SB-1];
      ovf_sticky_d = ovf_clr ? 1'b0 : ovf_sticky_q;
      if (v_q[SB-1] && ovf_any) ovf_sticky_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CMUL_LAT; i++) begin
            a_re_q[i] <= '0;
            a_im_q[i] <= '0;
         end
         for (int i = 0; i < SB; i++) begin
            v_q[i]   <= 1'b0;
            inv_q[i] <= 1'b0;
            sh_q[i]  <= '0;
         end
         acp_re_q <= '0;
         acp_im_q <= '0;
         acm_re_q <= '0;
         acm_im_q <= '0;
         bdp_re_q <= '0;
         bdp_im_q <= '0;
         bdm_re_q <= '0;
         bdm_im_q <= '0;
         for (int i = 0; i < 8; i++) p_q[i] <= '0;
         out_valid_q  <= 1'b0;
         ovf_sticky_q <= 1'b0;
      end else begin
         a_re_q   <= a_re_d;
         a_im_q   <= a_im_d;
         v_q      <= v_d;
         inv_q    <= inv_d;
         sh_q     <= sh_d;
         acp_re_q <= acp_re_d;
         acp_im_q <= acp_im_d;
         acm_re_q <= acm_re_d;
         acm_im_q <= acm_im_d;
         bdp_re_q <= bdp_re_d;
         bdp_im_q <= bdp_im_d;
         bdm_re_q <= bdm_re_d;
         bdm_im_q <= bdm_im_d;
         p_q      <= p_d;
         out_valid_q  <= out_valid_d;
         ovf_sticky_q <= ovf_sticky_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign ovf_sticky = ovf_sticky_q;
   assign p1_re = p_q[0];
   assign p1_im = p_q[1];
   assign p2_re = p_q[2];
   assign p2_im = p_q[3];
   assign p3_re = p_q[4];
   assign p3_im = p_q[5];
   assign p4_re = p_q[6];
   assign p4_im = p_q[7];

endmodule

// File: tb/tb_butterfly_radix4_pipe.sv
// Testbench for butterfly_radix4_pipe. A reference model computes each
// butterfly as a 4-point DFT (rotation by powers of -j or +j) on the
// twiddled operands; its results enter an expected queue and are compared
// against the DUT every cycle. Directed vectors add hand-computed literal
// expectations. Honours BFLY_R4_SATURATE_EN for the expected overflow result.
module tb_butterfly_radix4_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] x1_re = '0, x1_im = '0, x2_re = '0, x2_im = '0;
   logic [15:0] x3_re = '0, x3_im = '0, x4_re = '0, x4_im = '0;
   logic [15:0] cos0 = '0, sin0 = '0, cos1 = '0, sin1 = '0, cos2 = '0, sin2 = '0;
   logic        inv = 1'b0;
   logic [1:0]  scale = '0;
   logic        ovf_clr = 1'b0;
   logic        out_valid;
   logic [15:0] p1_re, p1_im, p2_re, p2_im, p3_re, p3_im, p4_re, p4_im;
   logic        ovf_sticky;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [7:0][15:0] v;
      logic             ovf;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       exp_hold = '0;
   logic [4:0] vpipe = '0;
   logic       m_sticky = 1'b0;
   int         mxr[4], mxi[4], mwr[3], mwi[3];

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   butterfly_radix4_pipe #(.DW(16), .TW(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .x1_re(x1_re), .x1_im(x1_im), .x2_re(x2_re), .x2_im(x2_im),
      .x3_re(x3_re), .x3_im(x3_im), .x4_re(x4_re), .x4_im(x4_im),
      .cos0(cos0), .sin0(sin0), .cos1(cos1), .sin1(sin1), .cos2(cos2), .sin2(sin2),
      .inv(inv), .scale(scale), .ovf_clr(ovf_clr),
      .out_valid(out_valid),
      .p1_re(p1_re), .p1_im(p1_im), .p2_re(p2_re), .p2_im(p2_im),
      .p3_re(p3_re), .p3_im(p3_im), .p4_re(p4_re), .p4_im(p4_im),
      .ovf_sticky(ovf_sticky));

   // ---------------- check helper ----------------
   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at %0t",
                  name, $signed(act), act, $signed(exp), exp, $time);
      end
   endtask

   function automatic logic [15:0] get_act(input int i);
      case (i)
         0: return p1_re;
         1: return p1_im;
         2: return p2_re;
         3: return p2_im;
         4: return p3_re;
         5: return p3_im;
         6: return p4_re;
         default: return p4_im;
      endcase
   endfunction

   // ---------------- reference model ----------------
   function automatic int wrap16(input longint v);
      logic [15:0] t;
      t = v[15:0];
      return int'($signed(t));
   endfunction

   function automatic logic [15:0] finish_val(input int v, input int s, output bit o);
      int r;
      r = (s == 0) ? v : ((v + (1 <<< (s - 1))) >>> s);
      o = (r > 32767) || (r < -32768);
`ifdef BFLY_R4_SATURATE_EN
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
`endif
      return 16'(r);
   endfunction

   function automatic exp_t model_bfly(input int xr[4], input int xi[4],
                                       input int wr[3], input int wi[3],
                                       input bit iv, input int sc);
      int     br[4], bi[4];
      int     s, r, im, tmp, acc_r, acc_i;
      bit     o;
      longint t;
      exp_t   e;
      br[0] = xr[0];
      bi[0] = xi[0];
      for (int n = 1; n < 4; n++) begin
         t = longint'(xr[n]) * wr[n-1] - longint'(xi[n]) * wi[n-1] + 16384;
         br[n] = wrap16(t >>> 15);
         t = longint'(xr[n]) * wi[n-1] + longint'(xi[n]) * wr[n-1] + 16384;
         bi[n] = wrap16(t >>> 15);
      end
      s = (sc > 2) ? 2 : sc;
      e = '0;
      for (int k = 0; k < 4; k++) begin
         acc_r = 0;
         acc_i = 0;
         for (int n = 0; n < 4; n++) begin
            r  = br[n];
            im = bi[n];
            for (int q = 0; q < (k * n) % 4; q++) begin
               tmp = r;
               if (!iv) begin r = im;  im = -tmp; end
               else     begin r = -im; im = tmp;  end
            end
            acc_r += r;
            acc_i += im;
         end
         e.v[2*k]   = finish_val(acc_r, s, o);
         if (o) e.ovf = 1'b1;
         e.v[2*k+1] = finish_val(acc_i, s, o);
         if (o) e.ovf = 1'b1;
      end
      return e;
   endfunction

   // Model timing: push on every accepted input, pop when it reaches the output.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         vpipe    = '0;
         exp_q.delete();
         exp_hold = '0;
         m_sticky = 1'b0;
      end else begin
         if (in_valid) begin
            mxr[0] = int'($signed(x1_re)); mxi[0] = int'($signed(x1_im));
            mxr[1] = int'($signed(x2_re)); mxi[1] = int'($signed(x2_im));
            mxr[2] = int'($signed(x3_re)); mxi[2] = int'($signed(x3_im));
            mxr[3] = int'($signed(x4_re)); mxi[3] = int'($signed(x4_im));
            mwr[0] = int'($signed(cos0));  mwi[0] = int'($signed(sin0));
            mwr[1] = int'($signed(cos1));  mwi[1] = int'($signed(sin1));
            mwr[2] = int'($signed(cos2));  mwi[2] = int'($signed(sin2));
            exp_q.push_back(model_bfly(mxr, mxi, mwr, mwi, inv, int'(scale)));
         end
         vpipe = {vpipe[3:0], in_valid};
         if (ovf_clr) m_sticky = 1'b0;
         if (vpipe[4]) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL exp_queue: got empty expected an entry at %0t", $time);
            end else begin
               exp_hold = exp_q.pop_front();
               if (exp_hold.ovf) m_sticky = 1'b1;
            end
         end
      end
   end

   // Compare process: every negedge, all outputs against the model.
   always @(negedge clk) begin
      chk("out_valid", {15'd0, out_valid}, {15'd0, vpipe[4]});
      for (int i = 0; i < 8; i++)
         chk($sformatf("p%0d_%s", i / 2 + 1, (i % 2) ? "im" : "re"), get_act(i), exp_hold.v[i]);
      chk("ovf_sticky", {15'd0, ovf_sticky}, {15'd0, m_sticky});
   end

   // ---------------- driver tasks ----------------
   task automatic set_vec(input int ar, ai, br, bi, cr, ci, dr, di,
                          input int w0r, w0i, w1r, w1i, w2r, w2i,
                          input bit iv, input int sc, input bit vld);
      x1_re = 16'(ar); x1_im = 16'(ai); x2_re = 16'(br); x2_im = 16'(bi);
      x3_re = 16'(cr); x3_im = 16'(ci); x4_re = 16'(dr); x4_im = 16'(di);
      cos0 = 16'(w0r); sin0 = 16'(w0i); cos1 = 16'(w1r); sin1 = 16'(w1i);
      cos2 = 16'(w2r); sin2 = 16'(w2i);
      inv = iv; scale = 2'(sc); in_valid = vld;
   endtask

   // One valid cycle, then idle until the fifth edge has produced the result.
   task automatic send_one(input int ar, ai, br, bi, cr, ci, dr, di,
                           input bit iv, input int sc);
      @(negedge clk);
      set_vec(ar, ai, br, bi, cr, ci, dr, di, 32767, 0, 32767, 0, 32767, 0, iv, sc, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   logic [3:0] pat;
   int         ov_cnt;

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
      chk("rst_p1_re", p1_re, 16'd0);
      chk("rst_ovf", {15'd0, ovf_sticky}, 16'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // DC input
      send_one(1000, 0, 1000, 0, 1000, 0, 1000, 0, 1'b0, 0);
      chk("dc_valid", {15'd0, out_valid}, 16'd1);
      chk("dc_p1_re", p1_re, 16'd4000);
      chk("dc_p1_im", p1_im, 16'd0);
      chk("dc_p2_re", p2_re, 16'd0);
      chk("dc_p3_re", p3_re, 16'd0);
      chk("dc_p4_im", p4_im, 16'd0);

      // Impulse on x2, forward then inverse
      send_one(0, 0, 1000, 0, 0, 0, 0, 0, 1'b0, 0);
      chk("imp_p1_re", p1_re, 16'd1000);
      chk("imp_p2_im", p2_im, -16'sd1000);
      chk("imp_p3_re", p3_re, -16'sd1000);
      chk("imp_p4_im", p4_im, 16'd1000);
      send_one(0, 0, 1000, 0, 0, 0, 0, 0, 1'b1, 0);
      chk("impi_p2_im", p2_im, 16'd1000);
      chk("impi_p4_im", p4_im, -16'sd1000);
      chk("impi_p2_re", p2_re, 16'd0);

      // Overflow without scaling
      send_one(20000, 0, 20000, 0, 20000, 0, 20000, 0, 1'b0, 0);
`ifdef BFLY_R4_SATURATE_EN
      chk("ovf_p1_re", p1_re, 16'd32767);
`else
      chk("ovf_p1_re", p1_re, 16'd14461);
`endif
      chk("ovf_p2_re", p2_re, 16'd1);
      chk("ovf_sticky_set", {15'd0, ovf_sticky}, 16'd1);

      // Same stimulus with scale=2 fits; sticky stays set
      send_one(20000, 0, 20000, 0, 20000, 0, 20000, 0, 1'b0, 2);
      chk("scl_p1_re", p1_re, 16'd19999);
      chk("scl_p2_re", p2_re, 16'd0);
      chk("scl_sticky", {15'd0, ovf_sticky}, 16'd1);

      // ovf_clr held while overflow recurs; clears only once the stream ends
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         set_vec(20000, 0, 20000, 0, 20000, 0, 20000, 0,
                 32767, 0, 32767, 0, 32767, 0, 1'b0, 0, i < 10);
         ovf_clr = (i >= 6);
         if (i >= 7 && i <= 12) chk("clr_hold_sticky", {15'd0, ovf_sticky}, 16'd1);
         if (i == 15) chk("clr_release_sticky", {15'd0, ovf_sticky}, 16'd0);
      end
      @(negedge clk);
      ovf_clr = 1'b0;

      // Throughput with bubbles: pattern 1,0,1,1
      pat = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         case (i)
            0: set_vec(1234, -567, -3000, 2500, 400, 800, -100, -20000,
                       23170, -23170, 0, -32767, -23170, -23170, 1'b0, 1, 1'b1);
            2: set_vec(-7000, 3000, 5000, 5000, -2000, 100, 3000, -3000,
                       30274, 12540, 23170, 23170, -12540, 30274, 1'b1, 3, 1'b1);
            3: set_vec(300, 300, -300, 300, 300, -300, -300, -300,
                       0, 32767, -32767, 0, 0, -32767, 1'b0, 0, 1'b1);
            default: in_valid = 1'b0;
         endcase
         if (i >= 5 && i <= 8) pat = {pat[2:0], out_valid};
      end
      chk("tput_pattern", {12'd0, pat}, 16'b1011);

      // Randomised back-to-back vectors
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         set_vec(int'($urandom_range(16000)) - 8000, int'($urandom_range(16000)) - 8000,
                 int'($urandom_range(16000)) - 8000, int'($urandom_range(16000)) - 8000,
                 int'($urandom_range(16000)) - 8000, int'($urandom_range(16000)) - 8000,
                 int'($urandom_range(16000)) - 8000, int'($urandom_range(16000)) - 8000,
                 int'($urandom_range(65534)) - 32767, int'($urandom_range(65534)) - 32767,
                 int'($urandom_range(65534)) - 32767, int'($urandom_range(65534)) - 32767,
                 int'($urandom_range(65534)) - 32767, int'($urandom_range(65534)) - 32767,
                 1'($urandom_range(1)), int'($urandom_range(3)), 1'b1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      repeat (6) @(negedge clk);

      // Reset with three valid inputs in flight
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         set_vec(1000 + i, 0, 2000, 0, 500, 0, 700, 0,
                 32767, 0, 32767, 0, 32767, 0, 1'b0, 0, 1'b1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("midrst_out_valid", {15'd0, out_valid}, 16'd0);
      chk("midrst_p1_re", p1_re, 16'd0);
      chk("midrst_p2_im", p2_im, 16'd0);
      chk("midrst_ovf", {15'd0, ovf_sticky}, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      ov_cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) ov_cnt++;
      end
      chk("postrst_no_stale", 16'(ov_cnt), 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
